// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI master and slave datapaths.
// Holds the master control-state encoding and the word-width helper.
// Both sides derive W from SPI_MAX_WIDTH_LOG through spi_width().
package spi_pkg;

  // Master control states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Word width in bits for a given log2 width
  function automatic int spi_width(input int width_log);
    return 1 << width_log;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: half-period divider and SCK toggler for the SPI master.
// Latency: one tick every CLK_DIV cycles while run=1; edge strobes coincide with the registered sck toggle.
// Backpressure: none; divider counts whenever run is high and reloads while run is low.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic toggle_en,
  input  logic idle_lvl,
  output logic tick,
  output logic sck,
  output logic sck_first_edge,
  output logic sck_second_edge
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] RELOAD = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          toggle;

  assign tick            = run && (div_cnt == '0);
  assign toggle          = tick && toggle_en;
  // Leaving the idle level is a first edge, returning to it is a second edge
  assign sck_first_edge  = toggle && (sck == idle_lvl);
  assign sck_second_edge = toggle && (sck != idle_lvl);

  // Half-period divider: reload at CLK_DIV-1, tick at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= RELOAD;
    end else if (!run || (div_cnt == '0)) begin
      div_cnt <= RELOAD;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  // SCK register: tracks the idle level when stopped, toggles on enabled ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      sck <= 1'b0;
    end else if (!run) begin
      sck <= idle_lvl;
    end else if (toggle) begin
      sck <= ~sck;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI initiator, LSB first on MOSI and MISO, runtime CPOL/CPHA.
// Latency: done pulses 1+(2W+1)*CLK_DIV cycles after the accepting edge (133 for W=16, CLK_DIV=4).
// Backpressure: start is accepted only while busy=0; requests during a frame are dropped, not queued.
module spi_master
  import spi_pkg::*;
#(
  parameter int SPI_MAX_WIDTH_LOG = 4,
  parameter int CLK_DIV           = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cpol,
  input  logic                                   cpha,
  input  logic                                   start,
  input  logic [spi_width(SPI_MAX_WIDTH_LOG)-1:0] din,
  output logic                                   busy,
  output logic                                   done,
  output logic [spi_width(SPI_MAX_WIDTH_LOG)-1:0] dout,
  output logic                                   sck,
  output logic                                   cs_n,
  output logic                                   mosi,
  input  logic                                   miso
);

  localparam int W  = spi_width(SPI_MAX_WIDTH_LOG);
  localparam int EW = SPI_MAX_WIDTH_LOG + 1;
  // The counter holds edges already seen, so the final edge arrives with 2W-1 stored
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * W - 1);

  logic [1:0]    state;
  logic          cpol_q;
  logic          cpha_q;
  logic [W-1:0]  tx_sr;
  logic [W-1:0]  rx_sr;
  logic [EW-1:0] edge_cnt;

  logic tick;
  logic first_edge;
  logic second_edge;
  logic any_edge;
  logic last_edge;
  logic accept;
  logic sample;
  logic shift;
  logic run;
  logic toggle_en;
  logic idle_lvl;

  assign run       = (state != ST_IDLE);
  assign toggle_en = (state == ST_SETUP) || (state == ST_XFER);
  // While idle sck tracks the live cpol input; during a frame it uses the latched copy
  assign idle_lvl  = run ? cpol_q : cpol;
  assign accept    = (state == ST_IDLE) && start;
  assign any_edge  = first_edge || second_edge;
  assign last_edge = (edge_cnt == LAST_EDGE);
  assign sample    = cpha_q ? second_edge : first_edge;
  // In mode cpha=0 bit 0 is already on MOSI, and nothing follows the final second edge
  assign shift     = cpha_q ? first_edge : (second_edge && !last_edge);

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .toggle_en      (toggle_en),
    .idle_lvl       (idle_lvl),
    .tick           (tick),
    .sck            (sck),
    .sck_first_edge (first_edge),
    .sck_second_edge(second_edge)
  );

  // Control FSM: frame sequencing, host handshake and chip select
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= '0;
      cs_n     <= 1'b1;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      edge_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cpol_q <= cpol;
          if (start) begin
            cpha_q   <= cpha;
            edge_cnt <= '0;
            busy     <= 1'b1;
            cs_n     <= 1'b0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (any_edge) begin
            edge_cnt <= edge_cnt + 1'b1;
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (any_edge) begin
            if (last_edge) begin
              edge_cnt <= '0;
              state    <= ST_HOLD;
            end else begin
              edge_cnt <= edge_cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            dout  <= rx_sr;
            busy  <= 1'b0;
            cs_n  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shift registers: load at accept, capture MISO on sample edges, advance MOSI on shift edges
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr <= '0;
      rx_sr <= '0;
      mosi  <= 1'b0;
    end else if (accept) begin
      rx_sr <= '0;
      if (cpha) begin
        tx_sr <= din;
      end else begin
        tx_sr <= din >> 1;
        mosi  <= din[0];
      end
    end else begin
      if (sample) begin
        rx_sr <= {miso, rx_sr[W-1:1]};
      end
      if (shift) begin
        mosi  <= tx_sr[0];
        tx_sr <= tx_sr >> 1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench for spi_master with a behavioural SPI slave.
// Expected sck/mosi/cs_n per cycle come from edge arithmetic (edge k visible at T0+1+k*CLK_DIV).
// Covers idle tracking, modes 0/3, ignored start, back-to-back frames, mid-frame reset, random frames.
module tb_spi_master;

  localparam int W        = 16;
  localparam int CD       = 4;
  localparam int DONE_LAT = 1 + (2 * W + 1) * CD;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         cpol  = 1'b0;
  logic         cpha  = 1'b0;
  logic         start = 1'b0;
  logic         miso  = 1'b0;
  logic [W-1:0] din   = '0;
  logic [W-1:0] dout;
  logic         busy;
  logic         done;
  logic         sck;
  logic         cs_n;
  logic         mosi;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  spi_master #(
    .SPI_MAX_WIDTH_LOG(4),
    .CLK_DIV          (CD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .cpol (cpol),
    .cpha (cpha),
    .start(start),
    .din  (din),
    .busy (busy),
    .done (done),
    .dout (dout),
    .sck  (sck),
    .cs_n (cs_n),
    .mosi (mosi),
    .miso (miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one frame from a negedge; acts as the slave and checks pins cycle by cycle.
  // inj_at: cycle (rel. T0) to pulse start with din=all-ones; rst_at: cycle to assert reset.
  task automatic run_frame(input logic pol, input logic pha,
                           input logic [W-1:0] d, input logic [W-1:0] sw,
                           input int inj_at, input int rst_at,
                           input bit keep_start, output int done_at);
    int t0, e, idx, rx_i, tx_i, rises, ctl_err, sck_err, mosi_err, quiet;
    bit aborted;
    logic prev_sck;
    logic [W-1:0] srx;
    done_at  = -1;
    ctl_err  = 0;
    sck_err  = 0;
    mosi_err = 0;
    quiet    = 0;
    aborted  = 0;
    cpol  = pol;
    cpha  = pha;
    din   = d;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc - 1;
    if (!keep_start) start = 1'b0;
    chk("accept_cs_n", 32'(cs_n), 32'd0);
    chk("accept_busy", 32'(busy), 32'd1);
    srx      = '0;
    rx_i     = 0;
    tx_i     = 0;
    rises    = 0;
    prev_sck = pol;
    if (!pha) begin
      miso = sw[0];
      tx_i = 1;
    end
    for (int r = 1; r <= DONE_LAT && !aborted; r++) begin
      e = (r - 1) / CD;
      if (e > 2 * W) e = 2 * W;
      if (r < DONE_LAT) begin
        if (busy !== 1'b1 || cs_n !== 1'b0 || done !== 1'b0) ctl_err++;
        if (sck !== (pol ^ e[0])) sck_err++;
        if (!pha) idx = (e / 2 > W - 1) ? W - 1 : e / 2;
        else      idx = (e + 1) / 2 - 1;
        if (idx >= 0 && mosi !== d[idx]) mosi_err++;
        if (sck !== prev_sck) begin
          if (sck == 1'b1) rises++;
          if ((prev_sck == pol) != pha) begin
            if (rx_i < W) begin
              srx[rx_i] = mosi;
              rx_i++;
            end
          end else if (tx_i < W) begin
            miso = sw[tx_i];
            tx_i++;
          end
          prev_sck = sck;
        end
      end else begin
        done_at = cyc;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_cs_n", 32'(cs_n), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("dout", 32'(dout), 32'(sw));
      end
      if (r == inj_at) begin
        start = 1'b1;
        din   = '1;
      end else if (r == inj_at + 1 && !keep_start) begin
        start = 1'b0;
      end
      if (r == rst_at) begin
        rst     = 1'b1;
        aborted = 1;
      end
      if (!aborted && r < DONE_LAT) @(negedge clk);
    end
    chk("frame_ctl", 32'(ctl_err), 32'd0);
    chk("frame_sck", 32'(sck_err), 32'd0);
    chk("frame_mosi", 32'(mosi_err), 32'd0);
    if (aborted) begin
      @(negedge clk);
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_sck", 32'(sck), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      repeat (DONE_LAT) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) quiet++;
      end
      chk("rst_no_done", 32'(quiet), 32'd0);
    end else begin
      chk("slave_rx", 32'(srx), 32'(d));
      chk("sck_rises", 32'(rises), 32'(W));
      if (!keep_start) begin
        repeat (2 * CD) begin
          @(negedge clk);
          if (done !== 1'b0 || busy !== 1'b0) quiet++;
        end
        chk("idle_after", 32'(quiet), 32'd0);
      end
    end
  endtask

  initial begin
    int d1;
    logic v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_done0", 32'(done), 32'd0);
    chk("rst_dout0", 32'(dout), 32'd0);
    chk("rst_sck0", 32'(sck), 32'd0);
    chk("rst_cs_n0", 32'(cs_n), 32'd1);
    chk("rst_mosi0", 32'(mosi), 32'd0);
    rst = 1'b0;

    // Idle: sck follows cpol one cycle later, no frame activity
    for (int i = 0; i < 4; i++) begin
      v = (i % 2 == 0);
      cpol = v;
      @(negedge clk);
      chk("idle_sck", 32'(sck), 32'(v));
      chk("idle_ctl", 32'({cs_n, busy, done}), 32'b100);
    end

    // Mode 0 and mode 3 directed frames
    run_frame(1'b0, 1'b0, 16'hA5C3, 16'h3C5A, 0, 0, 1'b0, d1);
    run_frame(1'b1, 1'b1, 16'h0001, 16'h8000, 0, 0, 1'b0, d1);

    // start and din disturbed mid-frame: ignored, single done
    run_frame(1'b0, 1'b1, 16'(32'($urandom)), 16'(32'($urandom)), 50, 0, 1'b0, d1);

    // Back-to-back: start held through done, next frame accepted at done+1
    run_frame(1'b0, 1'b0, 16'(32'($urandom)), 16'(32'($urandom)), 0, 0, 1'b1, d1);
    run_frame(1'b1, 1'b0, 16'(32'($urandom)), 16'(32'($urandom)), 0, 0, 1'b0, d1);

    // Reset mid-frame, then a clean frame
    run_frame(1'b1, 1'b1, 16'(32'($urandom)), 16'(32'($urandom)), 0, 60, 1'b0, d1);
    run_frame(1'b0, 1'b0, 16'(32'($urandom)), 16'(32'($urandom)), 0, 0, 1'b0, d1);

    // Random modes and data
    for (int i = 0; i < 6; i++) begin
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'(32'($urandom)), 16'(32'($urandom)), 0, 0, 1'b0, d1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
